mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage of the 5-stage pipeline, placed directly downstream of the execution unit. It consumes the execute-stage result bundle (ALU result, load/store address, destination register, opcode) and performs loads and stores against a local 16-word data memory with a configurable wait-state count. It produces the write-back bundle for the register file. While a memory access is in flight it stalls the upstream stages.

## Interface
- MEM_LAT, 2: wait states per load/store; legal range 0–7.
- clkwire  input  1  clock; all state changes on the rising edge.
- rstnwire  input  1  reset; synchronous, active-low.
- valid_in  input  1  execute bundle valid this cycle.
- ALU_output  input  16  execute result; store data for sw.
- ldst  input  4  data-memory word address for lw/sw.
- regdest  input  4  destination register index.
- instruction  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 lw, 0100 sw, 0101 beq, 0110 bne; 0111–1111 are treated as ALU ops.
- stall  output  1  upstream must hold its bundle; inputs are ignored while high.
- wb_data  output  16  write-back value.
- wb_regdest  output  4  write-back register index.
- wb_en  output  1  register-file write enable; qualified by wb_valid.
- wb_valid  output  1  one-cycle pulse; the write-back bundle is valid.

## Operation
- Storage is 16 x 16-bit words, indexed by ldst. There is no out-of-range case.
- FSM states are IDLE and WAIT.
- **IDLE, valid_in=1:** the bundle is captured.
  - ALU op (0000–0010, 0111–1111): wb_data=ALU_output, wb_regdest=regdest, wb_en=1, wb_valid=1 at the next edge. State stays IDLE.
  - Branch (0101/0110): wb_valid=1, wb_en=0, wb_data=ALU_output, wb_regdest=regdest. The register file is not written.
  - lw/sw with MEM_LAT=0: completes at the same edge as an ALU op.
    - lw: wb_data=mem[ldst], wb_en=1.
    - sw: mem[ldst]<=ALU_output, wb_en=0, wb_valid=1.
  - lw/sw with MEM_LAT>0: the wait counter loads MEM_LAT-1 and the state goes to WAIT.
- **IDLE, valid_in=0:** no action. wb_valid=0. Other outputs hold.
- **WAIT:**
  - stall=1 (combinational on state==WAIT). valid_in and the data inputs are ignored.
  - The counter decrements each edge.
  - On the edge where the counter is 0, the access completes as described for MEM_LAT=0, using the captured address, data, register and opcode. State returns to IDLE.
- A load always observes every store that completed at an earlier edge, including a store immediately preceding it.
- wb_data, wb_regdest and wb_en hold their last values between pulses. wb_valid is 0 except for exactly one cycle per accepted bundle.

## Timing
- **Reset** (rstnwire=0 at an edge):
  - State goes to IDLE and the counter to 0.
  - stall=0, wb_valid=0, wb_en=0, wb_data=0, wb_regdest=0.
  - All 16 memory words are cleared to 0.
  - Reset overrides every other event, including a completing access.
- **Reset during WAIT:** the pending access is aborted. A pending store is not committed. No wb_valid pulse occurs for it.
- **ALU/branch latency:** accepted at edge N, wb_valid high during cycle N..N+1.
- **lw/sw latency:**
  - Accepted at edge N.
  - stall is high from after edge N through edge N+MEM_LAT.
  - Completion is at edge N+MEM_LAT; wb_valid is high for the following cycle.
  - Throughput is one memory op per MEM_LAT+1 cycles.
- **Back-to-back bundles:**
  - The cycle in which WAIT exits to IDLE has stall=0.
  - A bundle presented in that cycle is accepted at the next edge.
  - No bubble is inserted beyond that.
- **Store data:** the value on ALU_output at acceptance is written, not the value at completion.

## Test plan
- **Reset:** drive rstnwire=0 for 2 edges mid-WAIT of a sw to addr 5 data 16'hBEEF -> all outputs 0, stall=0; a later lw from addr 5 returns 16'h0000.
- **ALU passthrough:** add bundle, ALU_output=16'h1234, regdest=3 -> the next cycle shows wb_valid=1, wb_en=1, wb_data=16'h1234, wb_regdest=3, and stall never rises.
- **Store then load, MEM_LAT=2:**
  - sw addr 9 data 16'hA5A5 -> stall high exactly 2 cycles, then wb_valid with wb_en=0.
  - Immediately follow with lw addr 9 to reg 7 -> wb_data=16'hA5A5, wb_regdest=7, wb_en=1, stall high 2 cycles.
- **Input isolation during WAIT:** during the lw wait, change ALU_output, ldst and regdest every cycle with valid_in=1 -> the result reflects only the captured bundle, and exactly one wb_valid pulse is produced.
- **Branch:** bne bundle with regdest=4 -> wb_valid=1, wb_en=0; a register-file model shows r4 unchanged.
- **MEM_LAT=0 build:** alternating sw/lw to addr 15 with data 16'hFFFF -> one completion per cycle, stall constantly 0, and lw returns 16'hFFFF.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Execute-to-memory bundle and write-back bundle of the memory-access stage.
// The master side is the execute stage; the slave side is the memory-access unit.
interface mem_access_unit_if;
    logic        valid_in;
    logic [15:0] ALU_output;
    logic [3:0]  ldst;
    logic [3:0]  regdest;
    logic [3:0]  instruction;
    logic        stall;
    logic [15:0] wb_data;
    logic [3:0]  wb_regdest;
    logic        wb_en;
    logic        wb_valid;

    modport master (
        output valid_in, ALU_output, ldst, regdest, instruction,
        input  stall, wb_data, wb_regdest, wb_en, wb_valid
    );

    modport slave (
        input  valid_in, ALU_output, ldst, regdest, instruction,
        output stall, wb_data, wb_regdest, wb_en, wb_valid
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: 16x16 local data memory with MEM_LAT wait states,
// stalls upstream while an lw/sw is pending and emits a one-cycle write-back bundle.
module mem_access_unit #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic             clkwire,
    input  logic             rstnwire,
    mem_access_unit_if.slave bus
);

    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_SW  = 4'b0100;
    localparam logic [3:0] OP_BEQ = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [2:0] CNT_LOAD = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [3:0]  op_q;
    logic [15:0] data_q;
    logic [3:0]  addr_q;
    logic [3:0]  rd_q;
    logic [15:0] wb_data_q;
    logic [3:0]  wb_regdest_q;
    logic        wb_en_q;
    logic        wb_valid_q;
    logic [15:0] mem_q [16];

    logic        start_wait_s;
    logic        complete_s;
    logic [3:0]  cur_op_s;
    logic [15:0] cur_data_s;
    logic [3:0]  cur_addr_s;
    logic [3:0]  cur_rd_s;
    logic [15:0] wb_data_d;
    logic        wb_en_d;

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Select the bundle being serviced (live inputs in IDLE, captured copy in WAIT) and decide completion.
    always_comb begin
        start_wait_s = 1'b0;
        complete_s   = 1'b0;
        cur_op_s     = bus.instruction;
        cur_data_s   = bus.ALU_output;
        cur_addr_s   = bus.ldst;
        cur_rd_s     = bus.regdest;
        if (state_q == WAIT) begin
            cur_op_s   = op_q;
            cur_data_s = data_q;
            cur_addr_s = addr_q;
            cur_rd_s   = rd_q;
            complete_s = (cnt_q == 3'd0);
        end else if (bus.valid_in) begin
            if (is_mem(bus.instruction) && (MEM_LAT != 0)) begin
                start_wait_s = 1'b1;
            end else begin
                complete_s = 1'b1;
            end
        end else begin
            complete_s = 1'b0;
        end
    end

    // Write-back value and enable for the completing bundle.
    always_comb begin
        wb_data_d = cur_data_s;
        wb_en_d   = 1'b1;
        case (cur_op_s)
            OP_LW: begin
                wb_data_d = mem_q[cur_addr_s];
                wb_en_d   = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                wb_data_d = cur_data_s;
                wb_en_d   = 1'b0;
            end
            default: begin
                wb_data_d = cur_data_s;
                wb_en_d   = 1'b1;
            end
        endcase
    end

    // Control FSM, bundle capture and registered write-back outputs.
    always_ff @(posedge clkwire) begin
        if (!rstnwire) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            op_q         <= 4'd0;
            data_q       <= 16'h0000;
            addr_q       <= 4'd0;
            rd_q         <= 4'd0;
            wb_data_q    <= 16'h0000;
            wb_regdest_q <= 4'd0;
            wb_en_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
        end else begin
            wb_valid_q <= complete_s;
            case (state_q)
                IDLE: begin
                    if (start_wait_s) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_LOAD;
                        op_q    <= bus.instruction;
                        data_q  <= bus.ALU_output;
                        addr_q  <= bus.ldst;
                        rd_q    <= bus.regdest;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
            if (complete_s) begin
                wb_data_q    <= wb_data_d;
                wb_regdest_q <= cur_rd_s;
                wb_en_q      <= wb_en_d;
            end
        end
    end

    // Data memory; a store commits only at its completion edge, so a reset in WAIT drops it.
    always_ff @(posedge clkwire) begin
        if (!rstnwire) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (complete_s && (cur_op_s == OP_SW)) begin
            mem_q[cur_addr_s] <= cur_data_s;
        end
    end

    assign bus.stall      = (state_q == WAIT);
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_regdest = wb_regdest_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_valid   = wb_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a MEM_LAT=2 instance and a MEM_LAT=0 instance
// driven on the falling edge and sampled on the falling edge.
module tb_mem_access_unit;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_SW  = 4'b0100;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [3:0] OP_X15 = 4'b1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    logic [15:0] rf [16];

    mem_access_unit_if bus ();
    mem_access_unit_if bus0 ();

    mem_access_unit #(.MEM_LAT(2)) dut (
        .clkwire  (clk),
        .rstnwire (rst_n),
        .bus      (bus)
    );

    mem_access_unit #(.MEM_LAT(0)) dut0 (
        .clkwire  (clk),
        .rstnwire (rst_n),
        .bus      (bus0)
    );

    always #5 clk = ~clk;

    // Register-file model fed by the write-back bundle of the MEM_LAT=2 instance.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (bus.wb_valid && bus.wb_en) begin
            rf[bus.wb_regdest] <= bus.wb_data;
        end
    end

    // Present one bundle at a falling edge; returns one falling edge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [15:0] alu,
                         input logic [3:0] addr, input logic [3:0] rd);
        bus.valid_in    = 1'b1;
        bus.instruction = op;
        bus.ALU_output  = alu;
        bus.ldst        = addr;
        bus.regdest     = rd;
        @(negedge clk);
        bus.valid_in    = 1'b0;
    endtask

    // Wait (bounded) for the write-back pulse, counting stalled cycles on the way.
    task automatic wait_wb(output int stalls, output bit seen);
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.wb_valid) begin
                seen = 1'b1;
            end else begin
                if (bus.stall) stalls++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        int st;
        bit seen;
        int pulses;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        nvec++; if (bus.wb_valid !== 1'b0) begin nerr++; $display("FAIL rst_wb_valid got=%b exp=0", bus.wb_valid); end
        nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
        nvec++; if (bus.wb_data !== 16'h0000) begin nerr++; $display("FAIL rst_wb_data got=%h exp=0000", bus.wb_data); end
        rst_n = 1'b1;
        issue(OP_SW, 16'h1111, 4'd5, 4'd0);
        wait_wb(st, seen);
        issue(OP_ADD, 16'h7777, 4'd0, 4'd6);
        wait_wb(st, seen);
        nvec++; if (bus.wb_data !== 16'h7777) begin nerr++; $display("FAIL pre_rst_data got=%h exp=7777", bus.wb_data); end
        issue(OP_SW, 16'hBEEF, 4'd5, 4'd0);
        nvec++; if (bus.stall !== 1'b1) begin nerr++; $display("FAIL mid_wait_stall got=%b exp=1", bus.stall); end
        rst_n = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.wb_valid) pulses++;
        end
        nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL rstw_stall got=%b exp=0", bus.stall); end
        nvec++; if (bus.wb_en !== 1'b0) begin nerr++; $display("FAIL rstw_wb_en got=%b exp=0", bus.wb_en); end
        nvec++; if (bus.wb_data !== 16'h0000) begin nerr++; $display("FAIL rstw_wb_data got=%h exp=0000", bus.wb_data); end
        nvec++; if (bus.wb_regdest !== 4'd0) begin nerr++; $display("FAIL rstw_wb_regdest got=%0d exp=0", bus.wb_regdest); end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.wb_valid) pulses++;
        end
        nvec++; if (pulses !== 0) begin nerr++; $display("FAIL rstw_pulses got=%0d exp=0", pulses); end
        issue(OP_LW, 16'h0000, 4'd5, 4'd1);
        wait_wb(st, seen);
        nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL rst_lw_seen got=%b exp=1", seen); end
        nvec++; if (bus.wb_data !== 16'h0000) begin nerr++; $display("FAIL rst_lw_data got=%h exp=0000", bus.wb_data); end
        nvec++; if (bus.wb_en !== 1'b1) begin nerr++; $display("FAIL rst_lw_en got=%b exp=1", bus.wb_en); end
        @(negedge clk);
    endtask

    task automatic test_alu();
        int st;
        bit seen;
        issue(OP_ADD, 16'h1234, 4'd0, 4'd3);
        wait_wb(st, seen);
        nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL alu_seen got=%b exp=1", seen); end
        nvec++; if (st !== 0) begin nerr++; $display("FAIL alu_stalls got=%0d exp=0", st); end
        nvec++; if (bus.wb_en !== 1'b1) begin nerr++; $display("FAIL alu_en got=%b exp=1", bus.wb_en); end
        nvec++; if (bus.wb_data !== 16'h1234) begin nerr++; $display("FAIL alu_data got=%h exp=1234", bus.wb_data); end
        nvec++; if (bus.wb_regdest !== 4'd3) begin nerr++; $display("FAIL alu_rd got=%0d exp=3", bus.wb_regdest); end
        @(negedge clk);
        nvec++; if (bus.wb_valid !== 1'b0) begin nerr++; $display("FAIL alu_pulse_end got=%b exp=0", bus.wb_valid); end
        nvec++; if (bus.wb_data !== 16'h1234) begin nerr++; $display("FAIL alu_hold got=%h exp=1234", bus.wb_data); end
        issue(OP_X15, 16'h00F0, 4'd0, 4'd15);
        wait_wb(st, seen);
        nvec++; if (bus.wb_en !== 1'b1 || bus.wb_data !== 16'h00F0 || bus.wb_regdest !== 4'd15 || st !== 0)
            begin nerr++; $display("FAIL op1111 got en=%b data=%h rd=%0d st=%0d exp en=1 data=00f0 rd=15 st=0", bus.wb_en, bus.wb_data, bus.wb_regdest, st); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int st;
        bit seen;
        issue(OP_SW, 16'hA5A5, 4'd9, 4'd2);
        wait_wb(st, seen);
        nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL sw_seen got=%b exp=1", seen); end
        nvec++; if (st !== 2) begin nerr++; $display("FAIL sw_stalls got=%0d exp=2", st); end
        nvec++; if (bus.wb_en !== 1'b0) begin nerr++; $display("FAIL sw_en got=%b exp=0", bus.wb_en); end
        nvec++; if (bus.stall !== 1'b0) begin nerr++; $display("FAIL sw_exit_stall got=%b exp=0", bus.stall); end
        issue(OP_LW, 16'h0000, 4'd9, 4'd7);
        nvec++; if (bus.wb_valid !== 1'b0) begin nerr++; $display("FAIL sw_pulse_len got=%b exp=0", bus.wb_valid); end
        wait_wb(st, seen);
        nvec++; if (st !== 2) begin nerr++; $display("FAIL lw_stalls got=%0d exp=2", st); end
        nvec++; if (bus.wb_data !== 16'hA5A5) begin nerr++; $display("FAIL lw_data got=%h exp=a5a5", bus.wb_data); end
        nvec++; if (bus.wb_regdest !== 4'd7) begin nerr++; $display("FAIL lw_rd got=%0d exp=7", bus.wb_regdest); end
        nvec++; if (bus.wb_en !== 1'b1) begin nerr++; $display("FAIL lw_en got=%b exp=1", bus.wb_en); end
        @(negedge clk);
    endtask

    task automatic test_isolation();
        int st;
        bit seen;
        int pulses;
        int stalls;
        logic [15:0] got_data;
        logic [3:0]  got_rd;
        pulses   = 0;
        stalls   = 0;
        got_data = 16'h0000;
        got_rd   = 4'd0;
        issue(OP_LW, 16'h0000, 4'd9, 4'd7);
        for (int i = 0; i < 10; i++) begin
            if (bus.wb_valid) begin
                pulses++;
                got_data = bus.wb_data;
                got_rd   = bus.wb_regdest;
                bus.valid_in = 1'b0;
            end else if (bus.stall) begin
                stalls++;
                bus.valid_in    = 1'b1;
                bus.instruction = OP_SW;
                bus.ALU_output  = 16'h1000 + 16'(i);
                bus.ldst        = (i % 2 == 0) ? 4'd3 : 4'd12;
                bus.regdest     = 4'(i + 8);
            end else begin
                bus.valid_in = 1'b0;
            end
            @(negedge clk);
        end
        nvec++; if (pulses !== 1) begin nerr++; $display("FAIL iso_pulses got=%0d exp=1", pulses); end
        nvec++; if (stalls !== 2) begin nerr++; $display("FAIL iso_stalls got=%0d exp=2", stalls); end
        nvec++; if (got_data !== 16'hA5A5) begin nerr++; $display("FAIL iso_data got=%h exp=a5a5", got_data); end
        nvec++; if (got_rd !== 4'd7) begin nerr++; $display("FAIL iso_rd got=%0d exp=7", got_rd); end
        issue(OP_LW, 16'h0000, 4'd3, 4'd5);
        wait_wb(st, seen);
        nvec++; if (bus.wb_data !== 16'h0000) begin nerr++; $display("FAIL iso_no_store got=%h exp=0000", bus.wb_data); end
        @(negedge clk);
    endtask

    task automatic test_branch();
        int st;
        bit seen;
        issue(OP_ADD, 16'h4444, 4'd0, 4'd4);
        wait_wb(st, seen);
        issue(OP_BNE, 16'h9999, 4'd0, 4'd4);
        nvec++; if (rf[4] !== 16'h4444) begin nerr++; $display("FAIL rf_pre got=%h exp=4444", rf[4]); end
        nvec++; if (bus.wb_valid !== 1'b1 || bus.wb_en !== 1'b0 || bus.wb_regdest !== 4'd4 || bus.wb_data !== 16'h9999)
            begin nerr++; $display("FAIL bne got v=%b en=%b rd=%0d data=%h exp v=1 en=0 rd=4 data=9999", bus.wb_valid, bus.wb_en, bus.wb_regdest, bus.wb_data); end
        @(negedge clk);
        nvec++; if (rf[4] !== 16'h4444) begin nerr++; $display("FAIL rf_r4 got=%h exp=4444", rf[4]); end
    endtask

    task automatic test_lat0();
        for (int k = 0; k < 4; k++) begin
            bus0.valid_in    = 1'b1;
            bus0.instruction = OP_SW;
            bus0.ALU_output  = 16'hFFFF;
            bus0.ldst        = 4'd15;
            bus0.regdest     = 4'd0;
            @(negedge clk);
            nvec++; if (bus0.wb_valid !== 1'b1 || bus0.wb_en !== 1'b0 || bus0.stall !== 1'b0)
                begin nerr++; $display("FAIL lat0_sw k=%0d got v=%b en=%b stall=%b exp v=1 en=0 stall=0", k, bus0.wb_valid, bus0.wb_en, bus0.stall); end
            bus0.instruction = OP_LW;
            bus0.ALU_output  = 16'h0000;
            bus0.regdest     = 4'(k + 1);
            @(negedge clk);
            nvec++; if (bus0.wb_valid !== 1'b1 || bus0.wb_en !== 1'b1 || bus0.stall !== 1'b0 || bus0.wb_data !== 16'hFFFF || bus0.wb_regdest !== 4'(k + 1))
                begin nerr++; $display("FAIL lat0_lw k=%0d got v=%b en=%b stall=%b data=%h rd=%0d exp v=1 en=1 stall=0 data=ffff rd=%0d", k, bus0.wb_valid, bus0.wb_en, bus0.stall, bus0.wb_data, bus0.wb_regdest, k + 1); end
        end
        bus0.valid_in = 1'b0;
        @(negedge clk);
        nvec++; if (bus0.wb_valid !== 1'b0) begin nerr++; $display("FAIL lat0_idle got=%b exp=0", bus0.wb_valid); end
    endtask

    initial begin
        bus.valid_in     = 1'b0;
        bus.instruction  = 4'd0;
        bus.ALU_output   = 16'h0000;
        bus.ldst         = 4'd0;
        bus.regdest      = 4'd0;
        bus0.valid_in    = 1'b0;
        bus0.instruction = 4'd0;
        bus0.ALU_output  = 16'h0000;
        bus0.ldst        = 4'd0;
        bus0.regdest     = 4'd0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_isolation();
        test_branch();
        test_lat0();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
